btb_update_arbiter: RTL and testbench



---
 rtl/btb_update_arbiter_pkg.sv | 38 +++
 rtl/btb_update_arbiter_upd_fifo.sv | 68 ++++++
 rtl/btb_update_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_btb_update_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_update_arbiter_pkg.sv
// Shared types for the BTB update arbiter: write kinds, FSM states, the
// queued FU update entry and the registered BTB write packet.
// The struct field widths come from the package constants below. The top
// level defaults its XLEN/BTB_LEN parameters to the same constants, so
// change both together.
package btb_update_arbiter_pkg;

    localparam int BTB_ARB_XLEN    = 32;
    localparam int BTB_ARB_BTB_LEN = 32;
    localparam int BTB_ARB_IDX_W   = $clog2(BTB_ARB_BTB_LEN);
    localparam int BTB_ARB_TAG_W   = BTB_ARB_XLEN - BTB_ARB_IDX_W - 2;

    typedef enum logic [1:0] {
        WR_INVAL  = 2'd0,
        WR_ALLOC  = 2'd1,
        WR_UPDATE = 2'd2
    } BTB_WR_KIND;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SWEEP = 1'b1
    } BTB_ARB_STATE;

    typedef struct packed {
        logic [BTB_ARB_XLEN-1:0] pc;
        logic [BTB_ARB_XLEN-1:0] target;
        logic                    taken;
    } BTB_UPD_ENTRY;

    typedef struct packed {
        BTB_WR_KIND               kind;
        logic [BTB_ARB_IDX_W-1:0] index;
        logic [BTB_ARB_TAG_W-1:0] tag;
        logic [BTB_ARB_XLEN-1:0]  target;
        logic                     taken;
    } BTB_WR_PACKET;

endpackage

// File: rtl/btb_update_arbiter_upd_fifo.sv
// btb_upd_fifo: 2-write / 1-read queue for resolved FU updates.
// Slot 0 is written ahead of slot 1. Occupancy is held in an explicit
// counter, so full and empty never depend on pointer equality. The caller
// never pushes more than the free space; pop is ignored when empty.
// Clear drops the contents, including a push in the same cycle.
module btb_upd_fifo #(
    parameter  int W     = 65,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic [1:0]       push_i,
    input  logic [W-1:0]     data0_i,
    input  logic [W-1:0]     data1_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_plus1;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_en;

    assign pop_en     = pop_i && (count_q != '0);
    assign wptr_plus1 = wptr_q + PTR_W'(1);
    assign head_o     = mem_q[rptr_q];
    assign count_o    = count_q;

    // Pointer and occupancy next-state; pointers wrap modulo DEPTH.
    always_comb begin
        wptr_d  = wptr_q + PTR_W'(push_i[0]) + PTR_W'(push_i[1]);
        rptr_d  = rptr_q + PTR_W'(pop_en);
        count_d = count_q + CNT_W'(push_i[0]) + CNT_W'(push_i[1]) - CNT_W'(pop_en);
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; slot 1 lands behind slot 0 when both push together.
    always_ff @(posedge clk) begin
        if (!clear_i) begin
            if (push_i[0]) mem_q[wptr_q] <= data0_i;
            if (push_i[1]) mem_q[push_i[0] ? wptr_plus1 : wptr_q] <= data1_i;
        end
    end

endmodule

// File: rtl/btb_update_arbiter.sv
// btb_update_arbiter: serialises all BTB writes through one write port.
// Queued FU updates win over decode allocation hints; a flush runs an
// invalidate sweep over every index. All btb_wr_* outputs are registered:
// a decision made in cycle N is visible in cycle N+1 for one cycle.
// Optional build macro BTB_ARB_STATS_EN adds saturating drop/stall counters.
//
// FU handshake: fu_upd_ready is a registered-state function (RUN and at
// least two free queue slots). An FU slot is accepted in a cycle exactly
// when its fu_upd_valid bit and fu_upd_ready are both 1; a valid while ready
// is 0 is a protocol error and is ignored. Allocation hints have no ready:
// they are either issued this cycle or dropped.
module btb_update_arbiter
    import btb_update_arbiter_pkg::*;
#(
    parameter  int BTB_LEN     = BTB_ARB_BTB_LEN,
    parameter  int XLEN        = BTB_ARB_XLEN,
    parameter  int QUEUE_DEPTH = 4,
    localparam int IDX_W       = $clog2(BTB_LEN),
    localparam int TAG_W       = XLEN - IDX_W - 2,
    localparam int CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_alloc_valid,
    input  logic [XLEN-1:0]   id_alloc_pc,
    input  logic [1:0]        fu_upd_valid,
    input  logic [2*XLEN-1:0] fu_upd_pc,
    input  logic [2*XLEN-1:0] fu_upd_target,
    input  logic [1:0]        fu_upd_taken,
    output logic              fu_upd_ready,
    input  logic              flush_req,
    output logic              sweep_busy,
    output logic              btb_wr_valid,
    output logic [1:0]        btb_wr_kind,
    output logic [IDX_W-1:0]  btb_wr_index,
    output logic [TAG_W-1:0]  btb_wr_tag,
    output logic [XLEN-1:0]   btb_wr_target,
    output logic              btb_wr_taken,
    output logic [CNT_W-1:0]  queue_count
`ifdef BTB_ARB_STATS_EN
    ,
    output logic [31:0]       stat_alloc_drop,
    output logic [31:0]       stat_fu_stall
`endif
);

    BTB_ARB_STATE     state_q, state_d;
    logic [IDX_W-1:0] sweep_cnt_q, sweep_cnt_d;   // next index to invalidate
    logic             wr_valid_q, wr_valid_d;
    BTB_WR_PACKET     wr_pkt_q, wr_pkt_d;

    BTB_UPD_ENTRY     fu0_entry, fu1_entry, q_head;
    logic [CNT_W-1:0] q_count;
    logic [1:0]       q_push;
    logic             q_pop;
    logic             q_clear;
    logic             fu_ready;
    logic             alloc_issue;
    logic             unused_pc_lsbs;

    assign fu0_entry = '{pc: fu_upd_pc[XLEN-1:0], target: fu_upd_target[XLEN-1:0],
                         taken: fu_upd_taken[0]};
    assign fu1_entry = '{pc: fu_upd_pc[2*XLEN-1:XLEN], target: fu_upd_target[2*XLEN-1:XLEN],
                         taken: fu_upd_taken[1]};

    // Byte-offset bits of a PC never reach the BTB.
    assign unused_pc_lsbs = ^{id_alloc_pc[1:0], q_head.pc[1:0]};

    assign fu_ready = (state_q == ST_RUN) &&
                      ((CNT_W'(QUEUE_DEPTH) - q_count) >= CNT_W'(2));

    btb_upd_fifo #(
        .W     ($bits(BTB_UPD_ENTRY)),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst_n   (reset),
        .clear_i (q_clear),
        .push_i  (q_push),
        .data0_i (fu0_entry),
        .data1_i (fu1_entry),
        .pop_i   (q_pop),
        .head_o  (q_head),
        .count_o (q_count)
    );

    // FSM next state, write-port arbitration and queue control.
    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        wr_valid_d  = 1'b0;
        wr_pkt_d    = '0;
        q_push      = fu_upd_valid & {2{fu_ready}};
        q_pop       = 1'b0;
        q_clear     = 1'b0;
        alloc_issue = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (flush_req) begin
                    // Index 0 goes out now; the counter tracks the next one.
                    q_clear       = 1'b1;
                    state_d       = ST_SWEEP;
                    wr_valid_d    = 1'b1;
                    wr_pkt_d.kind = WR_INVAL;
                    sweep_cnt_d   = IDX_W'(1);
                end else if (q_count != '0) begin
                    q_pop           = 1'b1;
                    wr_valid_d      = 1'b1;
                    wr_pkt_d.kind   = WR_UPDATE;
                    wr_pkt_d.index  = q_head.pc[IDX_W+1:2];
                    wr_pkt_d.tag    = q_head.pc[XLEN-1:IDX_W+2];
                    wr_pkt_d.target = q_head.target;
                    wr_pkt_d.taken  = q_head.taken;
                end else if (id_alloc_valid && (fu_upd_valid == 2'b00)) begin
                    alloc_issue     = 1'b1;
                    wr_valid_d      = 1'b1;
                    wr_pkt_d.kind   = WR_ALLOC;
                    wr_pkt_d.index  = id_alloc_pc[IDX_W+1:2];
                    wr_pkt_d.tag    = id_alloc_pc[XLEN-1:IDX_W+2];
                    wr_pkt_d.target = '0;
                    wr_pkt_d.taken  = 1'b1;
                end
            end
            ST_SWEEP: begin
                wr_valid_d    = 1'b1;
                wr_pkt_d.kind = WR_INVAL;
                if (flush_req) begin
                    q_clear     = 1'b1;
                    sweep_cnt_d = IDX_W'(1);
                end else begin
                    wr_pkt_d.index = sweep_cnt_q;
                    sweep_cnt_d    = sweep_cnt_q + IDX_W'(1);
                    if (sweep_cnt_q == IDX_W'(BTB_LEN - 1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM state and sweep counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            sweep_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
        end
    end

    // Registered BTB write port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_valid_q <= 1'b0;
            wr_pkt_q   <= '0;
        end else begin
            wr_valid_q <= wr_valid_d;
            wr_pkt_q   <= wr_pkt_d;
        end
    end

    assign btb_wr_valid  = wr_valid_q;
    assign btb_wr_kind   = wr_pkt_q.kind;
    assign btb_wr_index  = wr_pkt_q.index;
    assign btb_wr_tag    = wr_pkt_q.tag;
    assign btb_wr_target = wr_pkt_q.target;
    assign btb_wr_taken  = wr_pkt_q.taken;
    assign sweep_busy    = wr_valid_q && (wr_pkt_q.kind == WR_INVAL);
    assign fu_upd_ready  = fu_ready;
    assign queue_count   = q_count;

`ifdef BTB_ARB_STATS_EN
    logic [31:0] stat_alloc_drop_q;
    logic [31:0] stat_fu_stall_q;

    // Saturating counters for dropped allocs and stalled FU strobes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_alloc_drop_q <= '0;
            stat_fu_stall_q   <= '0;
        end else begin
            if (id_alloc_valid && !alloc_issue && (stat_alloc_drop_q != '1)) begin
                stat_alloc_drop_q <= stat_alloc_drop_q + 32'd1;
            end
            if (!fu_ready && (fu_upd_valid != 2'b00) && (stat_fu_stall_q != '1)) begin
                stat_fu_stall_q <= stat_fu_stall_q + 32'd1;
            end
        end
    end

    assign stat_alloc_drop = stat_alloc_drop_q;
    assign stat_fu_stall   = stat_fu_stall_q;
`endif

endmodule

// File: tb/tb_btb_update_arbiter.sv
// Testbench for btb_update_arbiter: directed scenarios followed by random
// traffic, checked every cycle against a queue-based reference model.
module tb_btb_update_arbiter;

    localparam int BTB_LEN = 32;
    localparam int XLEN    = 32;
    localparam int QD      = 4;
    localparam int IDX_W   = 5;
    localparam int TAG_W   = XLEN - IDX_W - 2;
    localparam int CNT_W   = 3;

    // ---------------- clock / reset / DUT ----------------
    logic              clock = 1'b0;
    logic              reset;
    logic              id_alloc_valid;
    logic [XLEN-1:0]   id_alloc_pc;
    logic [1:0]        fu_upd_valid;
    logic [2*XLEN-1:0] fu_upd_pc;
    logic [2*XLEN-1:0] fu_upd_target;
    logic [1:0]        fu_upd_taken;
    logic              fu_upd_ready;
    logic              flush_req;
    logic              sweep_busy;
    logic              btb_wr_valid;
    logic [1:0]        btb_wr_kind;
    logic [IDX_W-1:0]  btb_wr_index;
    logic [TAG_W-1:0]  btb_wr_tag;
    logic [XLEN-1:0]   btb_wr_target;
    logic              btb_wr_taken;
    logic [CNT_W-1:0]  queue_count;
`ifdef BTB_ARB_STATS_EN
    logic [31:0]       stat_alloc_drop;
    logic [31:0]       stat_fu_stall;
`endif

    always #5 clock = ~clock;

    btb_update_arbiter #(.BTB_LEN(BTB_LEN), .XLEN(XLEN), .QUEUE_DEPTH(QD)) dut (
        .clock          (clock),
        .reset          (reset),
        .id_alloc_valid (id_alloc_valid),
        .id_alloc_pc    (id_alloc_pc),
        .fu_upd_valid   (fu_upd_valid),
        .fu_upd_pc      (fu_upd_pc),
        .fu_upd_target  (fu_upd_target),
        .fu_upd_taken   (fu_upd_taken),
        .fu_upd_ready   (fu_upd_ready),
        .flush_req      (flush_req),
        .sweep_busy     (sweep_busy),
        .btb_wr_valid   (btb_wr_valid),
        .btb_wr_kind    (btb_wr_kind),
        .btb_wr_index   (btb_wr_index),
        .btb_wr_tag     (btb_wr_tag),
        .btb_wr_target  (btb_wr_target),
        .btb_wr_taken   (btb_wr_taken),
`ifdef BTB_ARB_STATS_EN
        .stat_alloc_drop(stat_alloc_drop),
        .stat_fu_stall  (stat_fu_stall),
`endif
        .queue_count    (queue_count)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } upd_t;

    upd_t        mq[$];          // pending FU updates, oldest first
    bit          m_sweeping;
    int          m_next;         // next index the sweep will invalidate
    bit          e_valid;
    int          e_kind;
    int          e_idx;
    logic [31:0] e_tag;
    logic [31:0] e_tgt;
    bit          e_taken;
    int          e_drop;
    int          e_stall;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_sweeping = 0;
        m_next     = 0;
        e_valid    = 0;
        e_kind     = 0;
        e_idx      = 0;
        e_tag      = '0;
        e_tgt      = '0;
        e_taken    = 0;
        e_drop     = 0;
        e_stall    = 0;
    endtask

    function automatic bit model_ready();
        return !m_sweeping && ((QD - mq.size()) >= 2);
    endfunction

    // Advance the model by one cycle using the inputs currently driven.
    task automatic model_step();
        bit   rdy;
        bit   issued_alloc;
        upd_t u;
        upd_t n;
        rdy          = model_ready();
        issued_alloc = 0;
        e_valid = 0; e_kind = 0; e_idx = 0; e_tag = '0; e_tgt = '0; e_taken = 0;
        if (flush_req) begin
            mq.delete();
            m_sweeping = 1;
            e_valid    = 1;
            m_next     = 1;
        end else if (m_sweeping) begin
            e_valid = 1;
            e_idx   = m_next;
            m_next++;
            if (m_next == BTB_LEN) m_sweeping = 0;
        end else begin
            if (mq.size() > 0) begin
                u       = mq.pop_front();
                e_valid = 1;
                e_kind  = 2;
                e_idx   = int'((u.pc >> 2) % BTB_LEN);
                e_tag   = u.pc >> (IDX_W + 2);
                e_tgt   = u.target;
                e_taken = u.taken;
            end else if (id_alloc_valid && fu_upd_valid == 2'b00) begin
                issued_alloc = 1;
                e_valid = 1;
                e_kind  = 1;
                e_idx   = int'((id_alloc_pc >> 2) % BTB_LEN);
                e_tag   = id_alloc_pc >> (IDX_W + 2);
                e_tgt   = '0;
                e_taken = 1;
            end
            if (rdy) begin
                for (int f = 0; f < 2; f++) begin
                    if (fu_upd_valid[f]) begin
                        n.pc     = fu_upd_pc[f*XLEN +: XLEN];
                        n.target = fu_upd_target[f*XLEN +: XLEN];
                        n.taken  = fu_upd_taken[f];
                        mq.push_back(n);
                    end
                end
            end
        end
        if (id_alloc_valid && !issued_alloc) e_drop++;
        if (!rdy && fu_upd_valid != 2'b00) e_stall++;
    endtask

    task automatic check_outputs();
        chk("wr_valid", btb_wr_valid, e_valid);
        chk("sweep_busy", sweep_busy, (e_valid && e_kind == 0));
        chk("fu_upd_ready", fu_upd_ready, model_ready());
        chk("queue_count", queue_count, mq.size());
        if (e_valid) begin
            chk("wr_kind", btb_wr_kind, e_kind);
            chk("wr_index", btb_wr_index, e_idx);
            chk("wr_tag", btb_wr_tag, e_tag);
            chk("wr_target", btb_wr_target, e_tgt);
            chk("wr_taken", btb_wr_taken, e_taken);
        end
`ifdef BTB_ARB_STATS_EN
        chk("stat_alloc_drop", stat_alloc_drop, e_drop);
        chk("stat_fu_stall", stat_fu_stall, e_stall);
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        id_alloc_valid = 0;
        id_alloc_pc    = '0;
        fu_upd_valid   = 2'b00;
        fu_upd_pc      = '0;
        fu_upd_target  = '0;
        fu_upd_taken   = 2'b00;
        flush_req      = 0;
    endtask

    // One clock: check outputs mid-cycle, then let the model consume inputs.
    task automatic step();
        @(negedge clock);
        check_outputs();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_fu(input logic [1:0] v,
                            input logic [31:0] pc0, input logic [31:0] tg0, input logic tk0,
                            input logic [31:0] pc1, input logic [31:0] tg1, input logic tk1);
        fu_upd_valid  = v;
        fu_upd_pc     = {pc1, pc0};
        fu_upd_target = {tg1, tg0};
        fu_upd_taken  = {tk1, tk0};
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        reset = 1'b0;
        model_reset();
        @(posedge clock); #1;
        @(negedge clock);
        check_outputs();                       // reset values
        @(posedge clock); #1;
        reset = 1'b1;

        // Alloc on an idle arbiter: index 2, tag 0x20.
        id_alloc_valid = 1; id_alloc_pc = 32'h0000_1008;
        step();
        idle();
        step();
        step();

        // Dual FU update, FU0 first.
        drive_fu(2'b11, 32'h100, 32'h180, 1'b1, 32'h200, 32'h300, 1'b0);
        step();
        idle();
        repeat (4) step();

        // Fill the queue with 2+2 back-to-back; concurrent alloc is dropped.
        drive_fu(2'b11, 32'h1000, 32'h2000, 1'b1, 32'h1004, 32'h2004, 1'b0);
        step();
        drive_fu(2'b11, 32'h1040, 32'h2040, 1'b0, 32'h1040, 32'h2080, 1'b1);
        id_alloc_valid = 1; id_alloc_pc = 32'h0000_3000;
        step();

        // Flush with three updates queued: queue discarded, full sweep.
        idle();
        flush_req = 1;
        step();
        idle();
        repeat (BTB_LEN + 3) step();

        // Flush mid-sweep restarts at index 0.
        flush_req = 1;
        step();
        idle();
        repeat (10) step();
        flush_req = 1;
        step();
        idle();
        repeat (BTB_LEN + 3) step();

        // Reset during a sweep with a partly filled queue history.
        drive_fu(2'b11, 32'h40, 32'h80, 1'b1, 32'h44, 32'h88, 1'b1);
        step();
        idle();
        flush_req = 1;
        step();
        idle();
        repeat (5) step();
        reset = 1'b0;
        #1;
        chk("rst_mid_sweep_wr_valid", btb_wr_valid, 1'b0);
        chk("rst_mid_sweep_busy", sweep_busy, 1'b0);
        model_reset();
        step();
        step();
        reset = 1'b1;
        repeat (3) step();

        // Random traffic.
        for (int c = 0; c < 800; c++) begin
            idle();
            if ($urandom_range(0, 2) == 0) begin
                drive_fu(2'($urandom_range(1, 3)),
                         $urandom, $urandom, 1'($urandom_range(0, 1)),
                         $urandom, $urandom, 1'($urandom_range(0, 1)));
            end
            id_alloc_valid = 1'($urandom_range(0, 1));
            id_alloc_pc    = $urandom;
            flush_req      = ($urandom_range(0, 99) == 0);
            step();
        end
        idle();
        repeat (BTB_LEN + 5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
